// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the fetch-sequencer state enum.
// Pure declarations, no logic; also consumed by debug/trace tooling.
package cpu_pkg;

  localparam int OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_CLA = 7'd0;
  localparam logic [OPCODE_W-1:0] OP_COM = 7'd1;
  localparam logic [OPCODE_W-1:0] OP_SHR = 7'd2;
  localparam logic [OPCODE_W-1:0] OP_CSL = 7'd3;
  localparam logic [OPCODE_W-1:0] OP_STP = 7'd4;
  localparam logic [OPCODE_W-1:0] OP_ADD = 7'd5;
  localparam logic [OPCODE_W-1:0] OP_STA = 7'd6;
  localparam logic [OPCODE_W-1:0] OP_LDA = 7'd7;
  localparam logic [OPCODE_W-1:0] OP_JMP = 7'd8;
  localparam logic [OPCODE_W-1:0] OP_BAN = 7'd9;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_FETCH,
    FS_LOAD,
    FS_ISSUE,
    FS_HALT
  } fetch_state_e;

  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    return op <= OP_BAN;
  endfunction

endpackage

// File: rtl/ins_next_pc.sv
// Next-PC select for a retiring instruction: increment, jump, taken/untaken BAN, or hold on STP.
// Purely combinational, zero latency; no flow control.
module ins_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [ADDR_W-1:0]   operand_i,
  input  logic                acc_neg_i,
  output logic [ADDR_W-1:0]   next_pc_o
);

  always_comb begin
    // Wraps modulo 2^ADDR_W; illegal opcodes fall through to the increment.
    next_pc_o = pc_i + ADDR_W'(1);
    case (opcode_i)
      OP_STP: next_pc_o = pc_i;
      OP_JMP: next_pc_o = operand_i;
      OP_BAN: if (acc_neg_i) next_pc_o = operand_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/ins_fetch.sv
// Fetch/sequencer: reads imem (1-cycle latency), holds the word in IR and issues it to control.
// 3 cycles start-to-issue; stalls in ISSUE until ex_done, so throughput is at most 1 instr per 3 cycles.
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                INS_W      = OPCODE_W + ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_rd,
  input  logic [INS_W-1:0]    imem_rdata,
  input  logic                acc_neg,
  input  logic                ex_done,
  output logic [OPCODE_W-1:0] ins,
  output logic [ADDR_W-1:0]   ins_operand,
  output logic                ins_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                illegal
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INS_W-1:0]    ir_q, ir_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic [ADDR_W-1:0]   next_pc;
  logic [OPCODE_W-1:0] ir_op;
  logic [OPCODE_W-1:0] rdata_op;

  assign ir_op    = ir_q[INS_W-1:ADDR_W];
  assign rdata_op = imem_rdata[INS_W-1:ADDR_W];

  ins_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i      (pc_q),
    .opcode_i  (ir_op),
    .operand_i (ir_q[ADDR_W-1:0]),
    .acc_neg_i (acc_neg),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FS_IDLE;
      pc_q      <= START_ADDR;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      FS_IDLE: begin
        if (start) begin
          pc_d    = START_ADDR;
          state_d = FS_FETCH;
        end
      end
      FS_FETCH: state_d = FS_LOAD;
      FS_LOAD: begin
        ir_d = imem_rdata;
        if (!op_is_legal(rdata_op)) illegal_d = 1'b1;
        state_d = FS_ISSUE;
      end
      FS_ISSUE: begin
        if (ex_done) begin
          pc_d = next_pc;
          if (ir_op == OP_STP) begin
            halted_d = 1'b1;
            state_d  = FS_HALT;
          end else begin
            state_d = FS_FETCH;
          end
        end
      end
      FS_HALT: begin
        // Restart keeps the sticky illegal flag so software can still inspect it.
        if (start) begin
          halted_d = 1'b0;
          pc_d     = START_ADDR;
          state_d  = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  assign imem_rd     = (state_q == FS_FETCH);
  assign imem_addr   = pc_q;
  assign ins         = ir_op;
  assign ins_operand = ir_q[ADDR_W-1:0];
  assign ins_valid   = (state_q == FS_ISSUE);
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: a 1-cycle-latency instruction memory plus an ISA-level model of
// program flow (which address is fetched next, which word is issued) checked per scenario.
module tb_ins_fetch;
  import cpu_pkg::*;

  localparam int AW = 8;
  localparam int IW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [IW-1:0] imem_rdata;
  logic          acc_neg;
  logic          ex_done;
  logic [6:0]    ins;
  logic [AW-1:0] ins_operand;
  logic          ins_valid;
  logic [AW-1:0] pc;
  logic          halted;
  logic          illegal;

  logic [IW-1:0] mem [256];
  int checks = 0;
  int failures = 0;

  ins_fetch #(.ADDR_W(AW), .START_ADDR(8'h00), .INS_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .acc_neg     (acc_neg),
    .ex_done     (ex_done),
    .ins         (ins),
    .ins_operand (ins_operand),
    .ins_valid   (ins_valid),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) imem_rdata <= '0;
    else if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  function automatic logic [IW-1:0] enc(input int op, input int opd);
    logic [IW-1:0] w;
    w = {op[6:0], opd[7:0]};
    return w;
  endfunction

  // ISA-level flow: address of the instruction that follows the one at pc_m.
  function automatic int model_next(input int pc_m, input logic [IW-1:0] w, input bit neg);
    int op;
    int opd;
    op  = int'(w[14:8]);
    opd = int'(w[7:0]);
    if (op == 8) return opd;
    if (op == 9 && neg) return opd;
    if (op == 4) return pc_m;
    return (pc_m + 1) % 256;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ex_done = 1'b0; acc_neg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fetch(output int faddr, output bit ok);
    ok = 1'b0; faddr = -1;
    for (int i = 0; i < 20; i++) begin
      if (imem_rd === 1'b1) begin
        faddr = int'(imem_addr); ok = 1'b1; break;
      end
      @(negedge clk);
    end
  endtask

  // Runs one instruction: observe its fetch address and issued word, then retire it.
  task automatic step(input bit neg, output int faddr, output int op, output int opd, output bit ok);
    op = -1; opd = -1;
    wait_fetch(faddr, ok);
    if (!ok) return;
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (ins_valid === 1'b1) begin
        op = int'(ins); opd = int'(ins_operand); ok = 1'b1; break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    acc_neg = neg; ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0; acc_neg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ex_done = 1'b0; acc_neg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_imem_rd got %b want 0", imem_rd); end
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_imem_addr got %h want 00", imem_addr); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got %h want 00", pc); end
    checks++; if ({ins, ins_operand} !== 15'h0) begin failures++; $display("FAIL reset_ins got %h/%h want 0/0", ins, ins_operand); end
    checks++; if ({ins_valid, halted, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {ins_valid, halted, illegal}); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_idle_no_fetch got %b want 0", imem_rd); end
  endtask

  task automatic test_first_fetch();
    do_reset(); clear_mem();
    mem[0] = enc(7, 'h10);
    kick();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL first_T1 got rd=%b addr=%h want rd=1 addr=00", imem_rd, imem_addr); end
    @(negedge clk);
    checks++; if (imem_rd !== 1'b0 || ins_valid !== 1'b0) begin failures++; $display("FAIL first_T2 got rd=%b vld=%b want 0 0", imem_rd, ins_valid); end
    @(negedge clk);
    checks++; if (ins_valid !== 1'b1 || ins !== 7'd7 || ins_operand !== 8'h10) begin failures++; $display("FAIL first_T3 got vld=%b ins=%0d opd=%h want 1 7 10", ins_valid, ins, ins_operand); end
    ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    checks++; if (pc !== 8'h01 || ins_valid !== 1'b0 || imem_rd !== 1'b1) begin failures++; $display("FAIL first_T4 got pc=%h vld=%b rd=%b want 01 0 1", pc, ins_valid, imem_rd); end
  endtask

  task automatic test_sequence();
    int fa, op, opd, rds;
    bit ok;
    int exp_op[3] = '{5, 6, 4};
    do_reset(); clear_mem();
    mem[0] = enc(5, 'h11); mem[1] = enc(6, 'h12); mem[2] = enc(4, 0);
    kick();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, fa, op, opd, ok);
      checks++; if (!ok || fa != k || op != exp_op[k]) begin failures++; $display("FAIL seq_issue%0d got ok=%0d addr=%0d op=%0d want addr=%0d op=%0d", k, ok, fa, op, k, exp_op[k]); end
    end
    checks++; if (halted !== 1'b1 || ins_valid !== 1'b0 || pc !== 8'h02) begin failures++; $display("FAIL seq_halt got halted=%b vld=%b pc=%h want 1 0 02", halted, ins_valid, pc); end
    rds = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_rd === 1'b1) rds++;
      @(negedge clk);
    end
    checks++; if (rds != 0 || halted !== 1'b1) begin failures++; $display("FAIL seq_no_fetch_in_halt got rds=%0d halted=%b want 0 1", rds, halted); end
    kick();
    checks++; if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL seq_restart got halted=%b rd=%b addr=%h want 0 1 00", halted, imem_rd, imem_addr); end
  endtask

  // Run from START_ADDR with the model predicting each fetch address and issued word.
  task automatic test_program(input string name, input int nsteps, input logic [63:0] negs, input bit randneg);
    int mpc, fa, op, opd;
    bit ok, neg;
    mpc = 0;
    kick();
    for (int s = 0; s < nsteps; s++) begin
      neg = randneg ? bit'($urandom_range(0, 1)) : negs[s];
      step(neg, fa, op, opd, ok);
      checks++;
      if (!ok || fa != mpc || op != int'(mem[mpc][14:8]) || opd != int'(mem[mpc][7:0])) begin
        failures++;
        $display("FAIL %s_step%0d got ok=%0d addr=%h op=%0d opd=%h want addr=%h op=%0d opd=%h",
                 name, s, ok, fa, op, opd, mpc, int'(mem[mpc][14:8]), int'(mem[mpc][7:0]));
      end
      mpc = model_next(mpc, mem[mpc], neg);
    end
    wait_fetch(fa, ok);
    checks++; if (!ok || fa != mpc) begin failures++; $display("FAIL %s_final_fetch got ok=%0d addr=%h want %h", name, ok, fa, mpc); end
  endtask

  task automatic test_branches();
    do_reset(); clear_mem();
    mem[0] = enc(8, 'h05); mem[5] = enc(8, 'h40); mem['h40] = enc(9, 'h20);
    test_program("jmp_ban_taken", 3, 64'b100, 1'b0);
    do_reset(); clear_mem();
    mem[0] = enc(8, 'h05); mem[5] = enc(9, 'h20);
    test_program("ban_not_taken", 2, 64'b00, 1'b0);
    do_reset(); clear_mem();
    mem[0] = enc(8, 'hFF); mem['hFF] = enc(0, 'h3C);
    test_program("wrap", 2, 64'b0, 1'b0);
    do_reset(); clear_mem();
    mem[0] = enc(8, 'h00);
    test_program("self_loop", 3, 64'b0, 1'b0);
  endtask

  task automatic test_illegal();
    int fa, op, opd;
    bit ok;
    do_reset(); clear_mem();
    mem[0] = enc(8, 'h03); mem[3] = enc(12, 'h55); mem[4] = enc(4, 0);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_pre got %b want 0", illegal); end
    test_program("illegal", 2, 64'b0, 1'b0);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_set got %b want 1", illegal); end
    step(1'b0, fa, op, opd, ok);
    checks++; if (!ok || halted !== 1'b1) begin failures++; $display("FAIL illegal_then_stp got ok=%0d halted=%b want 1 1", ok, halted); end
    kick();
    checks++; if (illegal !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL illegal_sticky got illegal=%b halted=%b want 1 0", illegal, halted); end
  endtask

  task automatic test_stall();
    bit seen;
    do_reset(); clear_mem();
    mem[0] = enc(6, 'h33); mem[1] = enc(1, 'h44);
    kick();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ins_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_reach_issue got timeout want ins_valid"); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (ins_valid !== 1'b1 || ins !== 7'd6 || ins_operand !== 8'h33) begin failures++; $display("FAIL stall_hold%0d got vld=%b ins=%0d opd=%h want 1 6 33", i, ins_valid, ins, ins_operand); end
      @(negedge clk);
    end
    ex_done = 1'b1;
    @(negedge clk);
    // ex_done stays high through FETCH and LOAD of the next word and must be ignored there.
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h01) begin failures++; $display("FAIL stall_release got rd=%b addr=%h want 1 01", imem_rd, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    ex_done = 1'b0;
    checks++; if (ins_valid !== 1'b1 || ins !== 7'd1 || ins_operand !== 8'h44) begin failures++; $display("FAIL done_in_fetch_load got vld=%b ins=%0d opd=%h want 1 1 44", ins_valid, ins, ins_operand); end
    @(negedge clk);
    checks++; if (ins_valid !== 1'b1 || pc !== 8'h01) begin failures++; $display("FAIL done_ignored_pc got vld=%b pc=%h want 1 01", ins_valid, pc); end
  endtask

  task automatic test_reset_mid();
    int fa, op, opd;
    bit ok;
    do_reset(); clear_mem();
    mem[0] = enc(8, 'h30); mem['h30] = enc(5, 'h77);
    kick();
    step(1'b0, fa, op, opd, ok);
    @(negedge clk);
    @(negedge clk);
    checks++; if (ins_valid !== 1'b1 || pc !== 8'h30) begin failures++; $display("FAIL rstmid_pre got vld=%b pc=%h want 1 30", ins_valid, pc); end
    ex_done = 1'b1; start = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if (ins_valid !== 1'b0 || pc !== 8'h00 || ins !== 7'd0) begin failures++; $display("FAIL rstmid_async got vld=%b pc=%h ins=%0d want 0 00 0", ins_valid, pc, ins); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; ex_done = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (imem_rd !== 1'b0 || ins_valid !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL rstmid_idle got rd=%b vld=%b pc=%h want 0 0 00", imem_rd, ins_valid, pc); end
    kick();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL rstmid_refetch got rd=%b addr=%h want 1 00", imem_rd, imem_addr); end
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      op = int'($urandom_range(0, 12));
      if (op == 4) op = 5;
      mem[i] = enc(op, int'($urandom_range(0, 255)));
    end
    test_program("random", 40, 64'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_sequence();
    test_branches();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch/sequencer for the accumulator CPU. It owns the program counter and reads instruction words from a synchronous instruction memory. It presents the opcode and operand to the control unit and resolves JMP, BAN and STP from the decoded opcode. It drives the control unit's instruction input and waits for the datapath to report completion before fetching the next word.

Parameters:
ADDR_W, 8, width of PC, instruction-memory address and operand field
START_ADDR, 0, PC value loaded on reset and on restart
INS_W, 7+ADDR_W, instruction word width: opcode in [INS_W-1:ADDR_W], operand in [ADDR_W-1:0]

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE/HALT and begin fetching at START_ADDR
imem_addr  out  ADDR_W  instruction memory read address
imem_rd  out  1  read strobe; data is valid on imem_rdata the following cycle
imem_rdata  in  INS_W  instruction word, one-cycle read latency
acc_neg  in  1  accumulator sign bit (MSB) from the datapath, used by BAN
ex_done  in  1  datapath has finished the issued instruction
ins  out  7  opcode to the control unit
ins_operand  out  ADDR_W  operand/address field of the issued instruction
ins_valid  out  1  ins/ins_operand hold a live instruction
pc  out  ADDR_W  address of the current instruction
halted  out  1  STP has been retired
illegal  out  1  sticky: an opcode greater than 7'd9 was fetched

Behaviour:
- Reset values (rst high, asynchronous): state=IDLE, pc=START_ADDR, IR=0, imem_rd=0, imem_addr=START_ADDR, ins=0, ins_operand=0, ins_valid=0, halted=0, illegal=0.
- The ins and ins_operand outputs are driven from the instruction register (IR), not from imem_rdata.
- Opcodes: CLA=0, COM=1, SHR=2, CSL=3, STP=4, ADD=5, STA=6, LDA=7, JMP=8, BAN=9.
- States: IDLE, FETCH, LOAD, ISSUE, HALT.
- IDLE: all outputs inactive. Move to FETCH when start=1.
- FETCH (1 cycle): imem_addr=pc, imem_rd=1. Always moves to LOAD.
- LOAD (1 cycle): imem_rd=0. IR<=imem_rdata at the end of the cycle. If the fetched opcode is >9, set illegal (sticky until reset). Move to ISSUE.
- ISSUE: ins_valid=1, with ins and ins_operand taken from IR. Hold until ex_done=1; ex_done is ignored in every other state. On the ex_done edge, ins_valid drops and:
  - STP: pc holds, halted<=1, move to HALT.
  - JMP: pc<=operand, move to FETCH.
  - BAN with acc_neg=1 (sampled on the ex_done edge): pc<=operand. BAN with acc_neg=0: pc<=pc+1. Move to FETCH.
  - Illegal opcode: treated as a no-op, pc<=pc+1, move to FETCH.
  - All other opcodes: pc<=pc+1, move to FETCH.
- Latency: start sampled at T0 -> FETCH at T1 -> LOAD at T2 -> ins_valid=1 at T3. With ex_done at T3, the next FETCH is at T4, so minimum throughput is 3 cycles per instruction.
- PC arithmetic: modulo 2^ADDR_W; pc=all-ones +1 wraps to 0. A jump target equal to pc is legal and gives a self-loop.
- HALT: halted=1, ins_valid=0, imem_rd=0. start=1 clears halted and loads pc=START_ADDR, then moves to FETCH. illegal is not cleared by start.
- start is ignored in FETCH, LOAD and ISSUE.
- Reset mid-operation: immediate return to reset values regardless of state. An in-flight ex_done is discarded. Reset has priority over a simultaneous start.

Decomposition:
- Shared package cpu_pkg: OPCODE_W=7, OP_CLA..OP_BAN opcode constants, and the fetch-state enum (shared with debug and trace logic).
- One sub-module, ins_next_pc: combinational next-PC selection from (pc, opcode, operand, acc_neg), covering increment, jump, conditional branch and hold.

Test Plan:
- Reset then start, with mem[0]=LDA 0x10 -> imem_rd at T1 with imem_addr=0x00; ins=7 and ins_operand=0x10 with ins_valid=1 at T3; pc=0x01 after ex_done.
- Sequence ADD, STA, STP at 0x00-0x02 with ex_done pulsed each ISSUE -> three issues, pc stops at 0x02, halted=1, ins_valid=0, and no further imem_rd.
- JMP 0x40 at 0x05 -> next imem_addr=0x40. BAN 0x20 with acc_neg=1 -> next imem_addr=0x20. The same BAN with acc_neg=0 -> next imem_addr=0x06.
- pc=0xFF holding CLA -> next imem_addr=0x00 (wrap). Opcode 7'd12 at 0x03 -> illegal=1, next fetch at 0x04, illegal stays 1 through a later start.
- ex_done held low for 10 cycles in ISSUE -> ins_valid stays 1 with ins stable; ex_done pulsed during FETCH/LOAD -> no effect.
- rst asserted during ISSUE, then start -> ins_valid=0 immediately, pc=START_ADDR, and the first fetch after start reads address 0x00.
